// File: rtl/shift_counter_if.sv
// Control/status bundle for shift_counter: step/load controls in, counter state and pulses out.
// The counter side uses the slave modport; whoever drives the controls uses master.
interface shift_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             illegal;

    modport master (
        output en, mode, dir, load, load_val,
        input  out, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output out, wrap, illegal
    );
endinterface

// File: rtl/shift_counter.sv
// Bidirectional ring / Johnson shift counter with parallel load and a wrap pulse.
// Define SHIFT_COUNTER_SELFCORRECT_EN to force illegal states back to the seed on the next step.
module shift_counter #(
    parameter int             WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic           clk,
    input  logic           reset,
    shift_counter_if.slave bus
);
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] rot_down;
    logic [WIDTH-1:0] rot_up;
    logic [WIDTH-1:0] step_val;

    // Johnson mode inverts the bit that wraps around the end of the register.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign rot_down[gi] = bus.mode ? ~out_reg[0] : out_reg[0];
            end else begin : g_mid_dn
                assign rot_down[gi] = out_reg[gi+1];
            end
            if (gi == 0) begin : g_bot
                assign rot_up[gi] = bus.mode ? ~out_reg[WIDTH-1] : out_reg[WIDTH-1];
            end else begin : g_mid_up
                assign rot_up[gi] = out_reg[gi-1];
            end
        end
    endgenerate

    assign seed     = bus.mode ? '0 : INIT;
    assign step_val = bus.dir ? rot_up : rot_down;

`ifdef SHIFT_COUNTER_SELFCORRECT_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] edge_bits;
    logic             state_legal;
    logic             illegal_reg;
    logic             illegal_next;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Circular neighbour differences; a Johnson state has at most two of them.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign edge_bits[gi] = out_reg[gi] ^ out_reg[(gi+1) % WIDTH];
        end
    endgenerate

    assign state_legal = bus.mode ? (popcount(edge_bits) <= CW'(2))
                                  : (popcount(out_reg) == CW'(1));

    always_comb begin
        out_next     = out_reg;
        wrap_next    = 1'b0;
        illegal_next = 1'b0;
        if (bus.load) begin
            out_next = bus.load_val;
        end else if (bus.en) begin
            if (!state_legal) begin
                out_next     = seed;
                illegal_next = 1'b1;
            end else begin
                out_next  = step_val;
                wrap_next = (step_val == seed);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_reg <= 1'b0;
        end else begin
            illegal_reg <= illegal_next;
        end
    end

    assign bus.illegal = illegal_reg;
`else
    always_comb begin
        out_next  = out_reg;
        wrap_next = 1'b0;
        if (bus.load) begin
            out_next = bus.load_val;
        end else if (bus.en) begin
            out_next  = step_val;
            wrap_next = (step_val == seed);
        end
    end

    assign bus.illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg  <= seed;
            wrap_reg <= 1'b0;
        end else begin
            out_reg  <= out_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bus.out  = out_reg;
    assign bus.wrap = wrap_reg;
endmodule
